// File: rtl/pci_arbiter_if.sv
// Arbitration bundle between the central PCI arbiter and the three on-chip
// functions: REQ#/GNT# lines, the bus FRAME#/IRDY# monitor inputs and the
// arbiter status outputs.
interface pci_arbiter_if #(
  parameter int N_MASTERS = 3
);
  localparam int OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic [N_MASTERS-1:0] req_n;
  logic                 frame_n;
  logic                 irdy_n;
  logic [N_MASTERS-1:0] gnt_n;
  logic [OW-1:0]        owner;
  logic                 gnt_valid;
  logic                 parked;
  logic                 timeout_o;
  logic                 bus_idle;

  // Arbiter side: samples requests and bus state, drives grants and status.
  modport master (
    input  req_n, frame_n, irdy_n,
    output gnt_n, owner, gnt_valid, parked, timeout_o, bus_idle
  );

  // Requester / fabric side: mirror of the arbiter view.
  modport slave (
    output req_n, frame_n, irdy_n,
    input  gnt_n, owner, gnt_valid, parked, timeout_o, bus_idle
  );
endinterface

// File: rtl/pci_arbiter.sv
// Central round-robin PCI bus arbiter with optional bus parking and a
// dead-master grant timeout. All inputs are registered before use and all
// outputs come straight from flops, so REQ# falling at edge k gives GNT#
// low at edge k+2. A grant is always separated from the next one by at
// least one cycle with every GNT# high.
module pci_arbiter #(
  parameter int N_MASTERS    = 3,
  parameter int PARK_EN      = 1,
  parameter int PARK_DEFAULT = 0,
  parameter int GNT_TIMEOUT  = 16
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  pci_arbiter_if.master bus
);
  localparam int OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GNT,
    ST_BUSY,
    ST_SWITCH
  } state_t;

  // Registered bus inputs
  logic [N_MASTERS-1:0] req_q;
  logic                 frame_q;
  logic                 irdy_q;
  logic                 idle;

  // Arbitration state
  state_t               state_reg, state_next;
  logic [OW-1:0]        owner_reg, owner_next;
  logic                 parked_reg, parked_next;
  logic [7:0]           timer_reg, timer_next;
  logic                 timeout_next;

  // Registered outputs
  logic [N_MASTERS-1:0] gnt_n_reg;
  logic                 gnt_valid_reg;
  logic                 timeout_reg;
  logic                 bus_idle_reg;

  // Helpers
  logic [N_MASTERS-1:0] own_onehot;
  logic [N_MASTERS-1:0] gnt_dec;
  logic                 any_req;
  logic                 other_req;
  logic                 grant_next;
  logic [OW-1:0]        pick;
  logic                 pick_found;

  assign idle      = frame_q & irdy_q;
  assign any_req   = |req_q;
  assign other_req = |(req_q & ~own_onehot);
  assign grant_next = (state_next == ST_GNT) || (state_next == ST_BUSY);

  // Per-master decode of the current owner and of the next-cycle grant.
  for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_dec
    assign own_onehot[gi] = (owner_reg == OW'(gi));
    assign gnt_dec[gi]    = ~(grant_next && (owner_next == OW'(gi)));
  end

  // Capture REQ#/FRAME#/IRDY# so every decision works on clean flops.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      req_q   <= '0;
      frame_q <= 1'b1;
      irdy_q  <= 1'b1;
    end else begin
      req_q   <= ~bus.req_n;
      frame_q <= bus.frame_n;
      irdy_q  <= bus.irdy_n;
    end
  end

  // Round-robin pick: first requester after the owner, the owner itself last.
  always_comb begin
    pick       = owner_reg;
    pick_found = 1'b0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      if (!pick_found && req_q[(int'(owner_reg) + k) % N_MASTERS]) begin
        pick       = OW'((int'(owner_reg) + k) % N_MASTERS);
        pick_found = 1'b1;
      end
    end
  end

  // Next-state logic for grant ownership, parking and the timeout timer.
  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    parked_next  = parked_reg;
    timer_next   = timer_reg;
    timeout_next = 1'b0;
    case (state_reg)
      // SWITCH is the mandatory all-high gap; it then decides exactly like IDLE.
      ST_IDLE, ST_SWITCH: begin
        if (any_req) begin
          owner_next  = pick;
          parked_next = 1'b0;
          timer_next  = '0;
          state_next  = ST_GNT;
        end else if ((PARK_EN != 0) && idle) begin
          parked_next = 1'b1;
          timer_next  = '0;
          state_next  = ST_GNT;
        end else begin
          parked_next = 1'b0;
          state_next  = ST_IDLE;
        end
      end
      ST_GNT: begin
        if (!frame_q) begin
          // Owner started a transaction; FRAME# beats a coincident timeout.
          parked_next = 1'b0;
          timer_next  = '0;
          state_next  = ST_BUSY;
        end else if (parked_reg && req_q[owner_reg]) begin
          parked_next = 1'b0;
        end else if (parked_reg && other_req) begin
          parked_next = 1'b0;
          state_next  = ST_SWITCH;
        end else if (!parked_reg && !req_q[owner_reg] && idle) begin
          state_next  = ST_SWITCH;
        end else if (!parked_reg && idle) begin
          if (timer_reg == 8'(GNT_TIMEOUT - 1)) begin
            timeout_next = 1'b1;
            state_next   = ST_SWITCH;
          end else begin
            timer_next = timer_reg + 8'd1;
          end
        end
      end
      ST_BUSY: begin
        if (other_req) begin
          // Hidden arbitration: pull GNT# now, owner finishes on its latency timer.
          parked_next = 1'b0;
          state_next  = ST_SWITCH;
        end else if (idle && !req_q[owner_reg]) begin
          if (PARK_EN != 0) begin
            parked_next = 1'b1;
            timer_next  = '0;
            state_next  = ST_GNT;
          end else begin
            parked_next = 1'b0;
            state_next  = ST_IDLE;
          end
        end
      end
      default: begin
        parked_next = 1'b0;
        state_next  = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; async reset drops every GNT# at once.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg     <= ST_IDLE;
      owner_reg     <= OW'(PARK_DEFAULT);
      parked_reg    <= 1'b0;
      timer_reg     <= '0;
      gnt_n_reg     <= '1;
      gnt_valid_reg <= 1'b0;
      timeout_reg   <= 1'b0;
      bus_idle_reg  <= 1'b1;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      parked_reg    <= parked_next;
      timer_reg     <= timer_next;
      gnt_n_reg     <= gnt_dec;
      gnt_valid_reg <= grant_next;
      timeout_reg   <= timeout_next;
      bus_idle_reg  <= bus.frame_n & bus.irdy_n;
    end
  end

  assign bus.gnt_n     = gnt_n_reg;
  assign bus.owner     = owner_reg;
  assign bus.gnt_valid = gnt_valid_reg;
  assign bus.parked    = parked_reg;
  assign bus.timeout_o = timeout_reg;
  assign bus.bus_idle  = bus_idle_reg;
endmodule
